// File: rtl/ysyx_23060077_exu_mdu_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
// Op encodings mirror funct3 so the decoder can forward the field untouched.
package ysyx_23060077_exu_mdu_pkg;

  localparam int MDU_OP_WIDTH = 3;

  typedef enum logic [MDU_OP_WIDTH-1:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  // rs1 is treated as signed by every op except the unsigned ones.
  function automatic logic op_signed_a(logic [MDU_OP_WIDTH-1:0] f);
    return (f == MDU_MUL) || (f == MDU_MULH) || (f == MDU_MULHSU) ||
           (f == MDU_DIV) || (f == MDU_REM);
  endfunction

  function automatic logic op_signed_b(logic [MDU_OP_WIDTH-1:0] f);
    return (f == MDU_MUL) || (f == MDU_MULH) || (f == MDU_DIV) || (f == MDU_REM);
  endfunction

endpackage

// File: rtl/ysyx_23060077_exu_mdu_if.sv
// Request/response channel between decoder, MDU and writeback mux.
import ysyx_23060077_exu_mdu_pkg::*;

interface ysyx_23060077_exu_mdu_if #(parameter int XLEN = 32);
  logic                    in_valid;
  logic                    in_ready;
  logic [MDU_OP_WIDTH-1:0] funct3;
  logic [XLEN-1:0]         src1;
  logic [XLEN-1:0]         src2;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         mdu_result;

  modport master (
    output in_valid, funct3, src1, src2, out_ready,
    input  in_ready, out_valid, mdu_result
  );

  modport slave (
    input  in_valid, funct3, src1, src2, out_ready,
    output in_ready, out_valid, mdu_result
  );
endinterface

// File: rtl/ysyx_23060077_exu_mdu_div.sv
// Restoring divider step datapath: one quotient bit per enabled step on magnitudes.
// quot_o/rem_o present the result of the current step so the caller can capture it on the last one.
module ysyx_23060077_mdu_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] prem_q, prem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dsor_q, dsor_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] prem_step;
  logic [XLEN-1:0] quot_step;

  always_comb begin
    shifted = {prem_q, quot_q[XLEN-1]};
    diff    = shifted - {1'b0, dsor_q};
    // A borrow out of the XLEN+1-bit subtract means the trial failed: restore.
    if (diff[XLEN]) begin
      prem_step = shifted[XLEN-1:0];
      quot_step = {quot_q[XLEN-2:0], 1'b0};
    end else begin
      prem_step = diff[XLEN-1:0];
      quot_step = {quot_q[XLEN-2:0], 1'b1};
    end

    prem_d = prem_q;
    quot_d = quot_q;
    dsor_d = dsor_q;
    if (load_i) begin
      prem_d = '0;
      quot_d = dividend_i;
      dsor_d = divisor_i;
    end else if (step_i) begin
      prem_d = prem_step;
      quot_d = quot_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prem_q <= '0;
      quot_q <= '0;
      dsor_q <= '0;
    end else begin
      prem_q <= prem_d;
      quot_q <= quot_d;
      dsor_q <= dsor_d;
    end
  end

  assign quot_o = quot_step;
  assign rem_o  = prem_step;

endmodule

// File: rtl/ysyx_23060077_exu_mdu.sv
// Multi-cycle RV M-extension execute unit: shift-add multiplier, restoring divider, sign fix-up.
//   state | meaning
//   IDLE  | ready for a request
//   CALC  | one multiplier/quotient bit per cycle, XLEN cycles
//   DONE  | result held until the writeback handshake
import ysyx_23060077_exu_mdu_pkg::*;

module ysyx_23060077_exu_mdu #(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  ysyx_23060077_exu_mdu_if.slave io
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    MDU_STATE_IDLE = 2'd0,
    MDU_STATE_CALC = 2'd1,
    MDU_STATE_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              sa_in, sb_in, accept, is_div, last_step;
  logic [XLEN-1:0]   a_mag, b_mag, quot_mag, rem_mag, quot_fix, rem_fix;
  logic [XLEN:0]     mac_sum;
  logic [2*XLEN-1:0] prod_step, prod_fix;

  assign sa_in  = op_signed_a(io.funct3) && io.src1[XLEN-1];
  assign sb_in  = op_signed_b(io.funct3) && io.src2[XLEN-1];
  assign a_mag  = sa_in ? -io.src1 : io.src1;
  assign b_mag  = sb_in ? -io.src2 : io.src2;
  assign accept = (state_q == MDU_STATE_IDLE) && io.in_valid && !flush;
  assign is_div = op_q[2];
  assign last_step = (cnt_q == CW'(XLEN - 1));

  // Multiplier lives in the low half of the accumulator and shifts out as product bits shift in.
  assign mac_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? a_q : {XLEN{1'b0}})};
  assign prod_step = {mac_sum, prod_q[XLEN-1:1]};
  assign prod_fix  = (sa_q ^ sb_q) ? -prod_step : prod_step;
  assign quot_fix  = (sa_q ^ sb_q) ? -quot_mag : quot_mag;
  assign rem_fix   = sa_q ? -rem_mag : rem_mag;

  ysyx_23060077_mdu_div #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .step_i     ((state_q == MDU_STATE_CALC) && is_div),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quot_o     (quot_mag),
    .rem_o      (rem_mag)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    prod_d  = prod_q;
    res_d   = res_q;

    case (state_q)
      MDU_STATE_IDLE: begin
        if (accept) begin
          op_d    = mdu_op_e'(io.funct3);
          sa_d    = sa_in;
          sb_d    = sb_in;
          a_d     = a_mag;
          prod_d  = {{XLEN{1'b0}}, b_mag};
          cnt_d   = '0;
          state_d = MDU_STATE_CALC;
          if (io.funct3[2] && (io.src2 == '0)) begin
            state_d = MDU_STATE_DONE;
            res_d   = io.funct3[1] ? io.src1 : ALL_ONES;
          end else if (io.funct3[2] && !io.funct3[0] &&
                       (io.src1 == MIN_NEG) && (io.src2 == ALL_ONES)) begin
            state_d = MDU_STATE_DONE;
            res_d   = io.funct3[1] ? '0 : io.src1;
          end
        end
      end
      MDU_STATE_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!is_div) prod_d = prod_step;
        if (last_step) begin
          state_d = MDU_STATE_DONE;
          case (op_q)
            MDU_MUL:                         res_d = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: res_d = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               res_d = quot_fix;
            default:                         res_d = rem_fix;
          endcase
        end
      end
      MDU_STATE_DONE: begin
        if (io.out_ready) state_d = MDU_STATE_IDLE;
      end
      default: state_d = MDU_STATE_IDLE;
    endcase

    if (flush) state_d = MDU_STATE_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDU_STATE_IDLE;
      op_q    <= MDU_MUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
    end
  end

  assign io.in_ready   = (state_q == MDU_STATE_IDLE);
  assign io.out_valid  = (state_q == MDU_STATE_DONE);
  assign io.mdu_result = res_q;

endmodule

// File: doc/ysyx_23060077_exu_mdu.md
# ysyx_23060077_exu_mdu

Parametrised multi-cycle multiply/divide execute unit implementing the eight RV M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-wide datapath. It sits beside the single-cycle ALU execute stage. The decoder routes M-extension instructions to it through a valid/ready request channel, and the writeback mux collects its result through a valid/ready response channel. A flush input aborts any in-flight operation on pipeline redirect.

## Interface
- `XLEN`, default 32: operand/result width; legal values 32 and 64.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `flush`  input  1: abort the current operation and return to idle.
- `in_valid`  input  1: request valid.
- `in_ready`  output  1: unit can accept a request; equals (state==IDLE).
- `funct3`  input  3: operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src1`  input  XLEN: rs1 operand (multiplicand/dividend).
- `src2`  input  XLEN: rs2 operand (multiplier/divisor).
- `out_valid`  output  1: result valid; held until accepted.
- `out_ready`  input  1: consumer accepts result.
- `mdu_result`  output  XLEN: registered result.

## Operation
- States: IDLE, CALC, DONE. Two-bit state register.
- IDLE: if in_valid && !flush:
  - latch funct3;
  - latch operand magnitudes and sign flags: sa = signed-op && src1[XLEN-1]; sb = signed ops other than MULHSU && src2[XLEN-1];
  - clear the step counter (width $clog2(XLEN)+1).
  - Next state is CALC, except for the division special cases, which go straight to DONE.
- Division special cases, resolved in IDLE:
  - divisor==0: DIV/DIVU give all ones; REM/REMU give src1.
  - Signed overflow (src1==100…0, src2==all ones, DIV/REM): DIV gives src1; REM gives 0.
- CALC, multiply: radix-2 shift-add on the magnitudes, one multiplier bit per cycle, into a 2·XLEN accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
- CALC exits to DONE after exactly XLEN steps (counter == XLEN-1 on the last step).
- Result fix-up on the CALC→DONE edge:
  - product negated if sa^sb; MUL returns product[XLEN-1:0], MULH* return product[2XLEN-1:XLEN];
  - quotient negated if sa^sb; remainder negated if sa.
  - All arithmetic is modulo 2^XLEN (or 2^(2XLEN) for the product).
- DONE: out_valid=1 and mdu_result stable. On out_valid && out_ready the unit goes to IDLE.
- flush: from any state, next state is IDLE and out_valid=0 next cycle. It takes priority over in_valid and over the out handshake in the same cycle; a request presented with flush is not accepted.
- Reset, mid-operation included: state=IDLE, out_valid=0, mdu_result=0, counter=0. in_ready therefore reads 1 while rst_n is low.

## Timing
- Handshake at edge 0 with a normal op: out_valid rises after edge XLEN+1, i.e. latency XLEN+1 cycles (33 for XLEN=32).
- Special-case divide: out_valid rises after edge 1 (latency 1).
- in_ready is low from the cycle after acceptance until the cycle after the output handshake, so there are no back-to-back acceptances. Minimum issue interval is XLEN+2 cycles.
- in_ready depends only on state; there is no combinational path from in_valid or out_ready to any output.
- out_valid holds indefinitely under out_ready=0. mdu_result does not change while out_valid=1.

## Structure
- Add to the shared define file: `MDU_OP_WIDTH` (3) and the eight funct3 op encodings as named macros; `MDU_STATE_*` encodings stay local to the module.
- One sub-module: `ysyx_23060077_mdu_div`, the restoring-divider step datapath (partial remainder and quotient registers, step enable, final magnitudes out).
- Multiplier, sign handling, FSM and fix-up live in the top module.

## Test plan
- XLEN=32, MUL 0x0000_0007×0xFFFF_FFFD → 0xFFFF_FFEB; out_valid exactly 33 cycles after acceptance.
- MULH/MULHSU/MULHU with src1=0x8000_0000, src2=0xFFFF_FFFF → 0x0000_0000 / 0x8000_0000 / 0x7FFF_FFFF.
- DIV −7/2 → 0xFFFF_FFFD; REM −7/2 → 0xFFFF_FFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV and REM by 0 with src1=0x1234 → 0xFFFF_FFFF and 0x1234; DIV 0x8000_0000/−1 → 0x8000_0000 with REM 0. All four complete with latency 1.
- out_ready held low for 10 cycles: out_valid and mdu_result stable and in_ready=0 throughout; accept, then a new request is accepted the following cycle.
- flush at CALC step 5, and flush coincident with in_valid in IDLE: unit idle next cycle, no out_valid, the following request computes correctly. rst_n pulsed low mid-CALC: all outputs at reset values immediately (asynchronous).
